// File: rtl/servo_pwm_multi_if.sv
// Servo PWM bus: position codes and enables in, pulse/frame/settled status out.
interface servo_pwm_multi_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned POS_W    = 8
);
  logic [CHANNELS*POS_W-1:0] POS;
  logic [CHANNELS-1:0]       EN;
  logic [CHANNELS-1:0]       PWM;
  logic                      FRAME;
  logic [CHANNELS-1:0]       SETTLED;

  modport master (output POS, output EN, input PWM, input FRAME, input SETTLED);
  modport slave  (input POS, input EN, output PWM, output FRAME, output SETTLED);
endinterface

// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator with frame-synchronous width updates.
// Optional slew limiting of width changes is compiled in with SERVO_SLEW_EN.
module servo_pwm_multi #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned POS_W     = 8,
  parameter int unsigned PERIOD    = 1000000,
  parameter int unsigned MIN_PULSE = 25000,
  parameter int unsigned STEP      = 392,
  parameter int unsigned SLEW_MAX  = 3920
) (
  input logic               CLK,
  input logic               RST,
  servo_pwm_multi_if.slave  bus
);

  localparam int unsigned CntW = $clog2(PERIOD);
  localparam int unsigned PwW  = $clog2(MIN_PULSE + (2**POS_W - 1) * STEP + 1);
  localparam int unsigned CmpW = (CntW > PwW) ? CntW : PwW;

`ifdef SERVO_SLEW_EN
  localparam bit SlewEn = 1'b1;
`else
  localparam bit SlewEn = 1'b0;
`endif

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CHANNELS-1:0] en_lat_q, en_lat_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic [CHANNELS-1:0] settled_q, settled_d;
  logic                frame_q, frame_d;
  logic [PwW-1:0]      cur_q [CHANNELS];
  logic [PwW-1:0]      cur_d [CHANNELS];
  logic [PwW-1:0]      tgt   [CHANNELS];
  logic                load;

  // Without slew the limit test folds away and the target is applied directly.
  function automatic logic [PwW-1:0] next_width(input logic [PwW-1:0] cur,
                                                input logic [PwW-1:0] target);
    logic [PwW-1:0] diff;
    diff = (target > cur) ? target - cur : cur - target;
    if (!SlewEn || 32'(diff) <= SLEW_MAX) return target;
    return (target > cur) ? cur + PwW'(SLEW_MAX) : cur - PwW'(SLEW_MAX);
  endfunction

  assign load = (cnt_q == CntW'(PERIOD - 1));

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      tgt[i] = PwW'(MIN_PULSE) + PwW'(bus.POS[i*POS_W +: POS_W]) * PwW'(STEP);
    end
  end

  always_comb begin
    cnt_d     = load ? '0 : cnt_q + CntW'(1);
    en_lat_d  = en_lat_q;
    settled_d = settled_q;
    frame_d   = load;
    for (int i = 0; i < CHANNELS; i++) begin
      cur_d[i] = cur_q[i];
    end
    if (load) begin
      en_lat_d = bus.EN;
      for (int i = 0; i < CHANNELS; i++) begin
        cur_d[i]     = next_width(cur_q[i], tgt[i]);
        settled_d[i] = (cur_d[i] == tgt[i]);
      end
    end
    // Output is registered, so decide from the count the flop will hold next.
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = en_lat_d[i] && (CmpW'(cnt_d) < CmpW'(cur_d[i]));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q     <= CntW'(PERIOD - 1);
      en_lat_q  <= '0;
      pwm_q     <= '0;
      settled_q <= '1;
      frame_q   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cur_q[i] <= PwW'(MIN_PULSE);
      end
    end else begin
      cnt_q     <= cnt_d;
      en_lat_q  <= en_lat_d;
      pwm_q     <= pwm_d;
      settled_q <= settled_d;
      frame_q   <= frame_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cur_q[i] <= cur_d[i];
      end
    end
  end

  assign bus.PWM     = pwm_q;
  assign bus.FRAME   = frame_q;
  assign bus.SETTLED = settled_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Scoreboard bench for servo_pwm_multi: stimulus pushes expected per-frame widths,
// a monitor measures each frame's pulses and compares.
module tb_servo_pwm_multi;

  localparam int Period = 1000;
  localparam int Slew   = 30;

  typedef struct packed {
    logic [3:0][15:0] w;
    logic [3:0]       settled;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = -1;
  int   checks = 0;
  int   failures = 0;
  bit   draining = 1'b0;
  rec_t sb[$];
  rec_t cur_rec;
  int   m_cur[4];
  int   tgt_drv[4];
  int   hi[4];
  bit   shape_err[4];
  bit   in_frame = 1'b0;

  servo_pwm_multi_if #(.CHANNELS(4), .POS_W(8)) bus ();

  servo_pwm_multi #(
    .CHANNELS (4),
    .POS_W    (8),
    .PERIOD   (Period),
    .MIN_PULSE(25),
    .STEP     (3),
    .SLEW_MAX (Slew)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int next_w(input int cur, input int tgt);
`ifdef SERVO_SLEW_EN
    if (tgt > cur) return (tgt - cur > Slew) ? cur + Slew : tgt;
    if (cur > tgt) return (cur - tgt > Slew) ? cur - Slew : tgt;
    return tgt;
`else
    return tgt;
`endif
  endfunction

  // tgt is the hand-computed width 25 + 3*pos.
  task automatic set_ch(input int ch, input int pos, input int tgt);
    bus.POS[ch*8 +: 8] = 8'(pos);
    tgt_drv[ch] = tgt;
  endtask

  // Expected contents of the frame loaded at the next wrap, given current drive.
  task automatic push_frame();
    rec_t r;
    for (int i = 0; i < 4; i++) begin
      m_cur[i]     = next_w(m_cur[i], tgt_drv[i]);
      r.w[i]       = bus.EN[i] ? 16'(m_cur[i]) : 16'd0;
      r.settled[i] = (m_cur[i] == tgt_drv[i]);
    end
    sb.push_back(r);
  endtask

  task automatic wait_at(input int f, input int p);
    while (cyc < f * Period + p) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pwm"}, int'(bus.PWM), 0);
    chk({tag, "_frame"}, int'(bus.FRAME), 0);
    chk({tag, "_settled"}, int'(bus.SETTLED), 15);
  endtask

  // Monitor: one record per frame, popped at the frame's first cycle.
  always @(negedge clk) begin
    if (cyc < 0) begin
      in_frame = 1'b0;
    end else begin
      int p;
      p = cyc % Period;
      if (p == 0) begin
        if (sb.size() > 0) begin
          cur_rec  = sb.pop_front();
          in_frame = 1'b1;
          for (int i = 0; i < 4; i++) begin
            hi[i] = 0;
            shape_err[i] = 1'b0;
          end
          chk("settled", int'(bus.SETTLED), int'(cur_rec.settled));
        end else begin
          in_frame = 1'b0;
          if (!draining) chk("scoreboard_empty", 1, 0);
        end
      end
      chk("frame_strobe", int'(bus.FRAME), int'(p == 0));
      if (in_frame) begin
        for (int i = 0; i < 4; i++) begin
          hi[i] += int'(bus.PWM[i]);
          if (bus.PWM[i] != (p < int'(cur_rec.w[i]))) shape_err[i] = 1'b1;
        end
        if (p == Period - 1) begin
          for (int i = 0; i < 4; i++) begin
            chk($sformatf("width_ch%0d_frame%0d", i, cyc / Period), hi[i], int'(cur_rec.w[i]));
            chk($sformatf("shape_ch%0d_frame%0d", i, cyc / Period), int'(shape_err[i]), 0);
          end
        end
      end
    end
  end

  initial begin
    bus.POS = '0;
    bus.EN  = 4'b0111;
    set_ch(0, 0, 25);
    set_ch(1, 255, 790);
    set_ch(2, 128, 409);
    set_ch(3, 0, 25);
    for (int i = 0; i < 4; i++) m_cur[i] = 25;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    push_frame();
    rst = 1'b0;

    wait_at(0, 500);
    push_frame();

    // ch0 0 -> 100 mid-frame: current frame unaffected.
    wait_at(1, 400);
    set_ch(0, 100, 325);
    push_frame();
    for (int f = 2; f <= 10; f++) begin
      wait_at(f, 500);
      push_frame();
    end

    wait_at(11, 500);
    set_ch(0, 0, 25);
    push_frame();
    for (int f = 12; f <= 21; f++) begin
      wait_at(f, 500);
      push_frame();
    end

    // Drop EN[1] mid-pulse, then re-assert early in the disabled frame.
    wait_at(22, 500);
    bus.EN = 4'b0101;
    push_frame();
    wait_at(23, 10);
    bus.EN = 4'b0111;
    push_frame();

    // Reset while ch1 is high.
    wait_at(24, 100);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    for (int i = 0; i < 4; i++) m_cur[i] = 25;
    @(negedge clk);
    push_frame();
    rst = 1'b0;

    wait_at(0, 500);
    push_frame();
    draining = 1'b1;
    wait_at(1, 999);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_pwm_multi.md
# servo_pwm_multi

Multi-channel hobby-servo PWM generator. Converts a per-channel position code into a pulse width inside a fixed frame (default 20 ms at 50 MHz), drives one PWM pin per channel, and optionally slew-limits pulse-width changes. Sits between the arm's joint-position logic and the servo output pins. It replaces the single-channel angle-to-pulse block.

## Interface
- CHANNELS, 4, number of servo channels
- POS_W, 8, position code width per channel
- PERIOD, 1000000, frame length in CLK cycles
- MIN_PULSE, 25000, pulse width in cycles for code 0
- STEP, 392, cycles added per code LSB
- SLEW_MAX, 3920, maximum width change per frame per channel (used only with slew compiled in)

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- POS  in  CHANNELS*POS_W  position codes; channel i in bits [i*POS_W +: POS_W]
- EN  in  CHANNELS  per-channel output enable
- PWM  out  CHANNELS  servo pulse outputs, registered
- FRAME  out  1  one-cycle strobe in the first cycle of every frame, registered
- SETTLED  out  CHANNELS  1 when the channel's applied width equals its target

## Operation
- Frame counter CNT, width $clog2(PERIOD), counts 0..PERIOD-1 and wraps.
- Width registers: PW_W = $clog2(MIN_PULSE + (2**POS_W-1)*STEP + 1) bits (17 at defaults). Require MIN_PULSE + (2**POS_W-1)*STEP < PERIOD.
- Target: TGT_i = MIN_PULSE + POS_i*STEP, computed at full PW_W width with no truncation.
- Frame load happens on the edge where CNT wraps PERIOD-1 -> 0. POS and EN are sampled only on that edge. Per channel it latches EN_i and updates applied width CUR_i.
- PWM_i is high in frame cycles CNT = 0 .. CUR_i-1 when latched EN_i = 1, i.e. exactly CUR_i cycles per frame. Otherwise it is low for the whole frame.
- FRAME = 1 exactly when CNT = 0.
- SETTLED_i = (CUR_i == TGT_i as sampled at the last load). It updates with the load.
- Changes to POS/EN mid-frame have no effect until the next load. There is no tearing within a frame.
- Reset values: CNT = PERIOD-1, CUR_i = MIN_PULSE, latched EN = 0, PWM = 0, FRAME = 0, SETTLED = all 1. The first edge with RST low performs a frame load.
- RST asserted mid-frame: all outputs go to reset values on that edge, with PWM forced low immediately.

## Timing
- PWM and FRAME are driven straight from flops and are glitch-free. They are asserted in the same cycle in which CNT holds the corresponding value.
- Latency from POS change to output: the POS value present at the next load edge appears starting in the very next cycle (CNT = 0). Worst case is PERIOD cycles, plus slew frames if slew is enabled.
- All channels load simultaneously, and all pulses rise together in the CNT = 0 cycle.
- CUR_i = 0 is not reachable. MIN_PULSE is at least 1 by requirement.

## Configuration
- SERVO_SLEW_EN defined: at each load, CUR_i moves toward TGT_i by min(|TGT_i - CUR_i|, SLEW_MAX). SETTLED_i is low while the remaining difference is nonzero. Slewing continues while EN_i = 0.
- SERVO_SLEW_EN undefined: CUR_i = TGT_i at every load. SETTLED is constantly 1 after reset. SLEW_MAX is ignored.

## Test plan
Bench parameters: PERIOD=1000, MIN_PULSE=25, STEP=3, SLEW_MAX=30, CHANNELS=4, POS_W=8.
- Reset: hold RST 3 cycles -> PWM=0, FRAME=0, SETTLED=4'hF. The first cycle after release has FRAME=1, and FRAME recurs every 1000 cycles.
- Static widths, slew off: POS ch0=0, ch1=255, ch2=128, EN=4'b0111 -> high times per frame are 25, 790 and 409 cycles. ch3 stays low and all pulses rise at CNT=0.
- Mid-frame change, slew off: ch0 0->100 at CNT=400 -> current frame 25 cycles, next frame 325 cycles.
- Slew on: ch0 0->100 held -> widths 55, 85, ..., 325 over 10 frames. SETTLED[0] is low for frames 1-9 and rises with the frame whose width is 325. Then 100->0 gives 295, 265, ..., 25.
- Enable: EN[1] dropped mid-frame -> the current pulse completes, the next frame is low, and FRAME still pulses. Re-asserting EN[1] at CNT=10 has no effect until the next frame.
- Reset mid-pulse: RST at CNT=100 with ch1 width 790 -> PWM=0 on the next edge. After release, widths restart from 25 (slew on) or jump to target (slew off).
